alu_muldiv: RTL and testbench



---
 rtl/alu_pkg.sv | 33 +++
 rtl/md_sign_fix.sv | 17 +
 rtl/alu_muldiv.sv | 202 ++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the iterative RV32M multiply/divide unit.
//   md_op_e    - 3-bit M-extension operation encoding (funct3 order)
//   md_state_e - control FSM states
//   is_div()   - true for DIV/DIVU/REM/REMU
//   is_rem()   - true for REM/REMU (remainder rather than quotient)
package alu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  function automatic logic is_div(input md_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(input md_op_e op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/md_sign_fix.sv
// md_sign_fix: conditional two's-complement negator.
//   WIDTH  - data width (DATA_WIDTH for operands/quotients, 2*DATA_WIDTH
//            for full products)
//   data_i - value to condition
//   neg_i  - 1: output -data_i, 0: output data_i unchanged
//   data_o - conditioned value
module md_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] data_o
);

  assign data_o = neg_i ? (~data_i + WIDTH'(1)) : data_i;

endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M multiply/divide unit (radix-2 shift-add
// multiply, restoring divide, one bit per cycle).
//   clk, rst_n            - clock, synchronous active-low reset
//   in_valid / in_ready   - request handshake (in_ready == IDLE)
//   op, src_a, src_b      - md_op_e opcode, rs1 and rs2 operands
//   flush                 - abort any in-flight operation, drop result
//   out_valid / out_ready - result handshake (out_valid == DONE)
//   out_result            - registered result, stable while out_valid
module alu_muldiv
  import alu_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result
);

  localparam int W = DATA_WIDTH;

  md_op_e    op_in;
  md_state_e state_q, state_d;
  md_op_e    op_q, op_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 sign_q, sign_d;
  // Multiply: multiplicand magnitude. Divide: divisor magnitude.
  logic [W-1:0]   opnd_q, opnd_d;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide: low half holds dividend bits shifting out / quotient bits in.
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   res_q, res_d;

  assign op_in = md_op_e'(op);

  // ---------------- operand conditioning ----------------
  logic         a_signed, b_signed, a_neg, b_neg;
  logic [W-1:0] a_mag, b_mag;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op_in)
      OP_MULH, OP_DIV, OP_REM: begin a_signed = 1'b1; b_signed = 1'b1; end
      OP_MULHSU:               a_signed = 1'b1;
      default:                 ;
    endcase
  end

  assign a_neg = a_signed & src_a[W-1];
  assign b_neg = b_signed & src_b[W-1];

  md_sign_fix #(.WIDTH(W)) u_fix_a (.data_i(src_a), .neg_i(a_neg), .data_o(a_mag));
  md_sign_fix #(.WIDTH(W)) u_fix_b (.data_i(src_b), .neg_i(b_neg), .data_o(b_mag));

  // ---------------- special cases (resolved at accept) ----------------
  logic         div_zero, div_ovf;
  logic [W-1:0] special_res;

  assign div_zero = is_div(op_in) && (src_b == '0);
  assign div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                    (src_a == {1'b1, {(W-1){1'b0}}}) && (&src_b);

  always_comb begin
    special_res = '0;  // REM overflow case returns zero
    if (div_zero)
      special_res = is_rem(op_in) ? src_a : '1;
    else if (op_in == OP_DIV)
      special_res = {1'b1, {(W-1){1'b0}}};
  end

  // ---------------- one iteration of each datapath ----------------
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_step;
  logic [W:0]     div_shift;
  logic           div_ge;
  logic [W-1:0]   rem_sub, rem_step, quo_step;

  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} +
                    (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
  assign mul_step = {mul_sum, acc_q[W-1:1]};

  // The shifted partial remainder is W+1 bits; when its top bit is set it
  // certainly exceeds the divisor, and the true difference fits in W bits.
  assign div_shift = {rem_q, acc_q[W-1]};
  assign div_ge    = div_shift[W] || (div_shift[W-1:0] >= opnd_q);
  assign rem_sub   = div_shift[W-1:0] - opnd_q;
  assign rem_step  = div_ge ? rem_sub : div_shift[W-1:0];
  assign quo_step  = {acc_q[W-2:0], div_ge};

  // ---------------- result sign correction ----------------
  logic [2*W-1:0] prod_fixed;
  logic [W-1:0]   div_raw, div_fixed, calc_res;

  assign div_raw = is_rem(op_q) ? rem_step : quo_step;

  md_sign_fix #(.WIDTH(2*W)) u_fix_prod (.data_i(mul_step), .neg_i(sign_q), .data_o(prod_fixed));
  md_sign_fix #(.WIDTH(W))   u_fix_div  (.data_i(div_raw),  .neg_i(sign_q), .data_o(div_fixed));

  always_comb begin
    calc_res = prod_fixed[2*W-1:W];
    if (is_div(op_q))
      calc_res = div_fixed;
    else if (op_q == OP_MUL)
      calc_res = prod_fixed[W-1:0];
  end

  // ---------------- control FSM ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sign_d  = sign_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    res_d   = res_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_d  = op_in;
            rem_d = '0;
            if (is_div(op_in)) begin
              opnd_d = b_mag;
              acc_d  = {{W{1'b0}}, a_mag};
              sign_d = is_rem(op_in) ? a_neg : (a_neg ^ b_neg);
            end else begin
              opnd_d = a_mag;
              acc_d  = {{W{1'b0}}, b_mag};
              sign_d = a_neg ^ b_neg;
            end
            if (div_zero || div_ovf) begin
              state_d = ST_DONE;
              res_d   = special_res;
            end else begin
              state_d = ST_CALC;
              cnt_d   = CNT_WIDTH'(W);
            end
          end
        end
        ST_CALC: begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
          if (is_div(op_q)) begin
            acc_d = {acc_q[2*W-1:W], quo_step};
            rem_d = rem_step;
          end else begin
            acc_d = mul_step;
          end
          // Final iteration: register the corrected result from this
          // iteration's values so out_result is ready on entry to DONE.
          if (cnt_q == CNT_WIDTH'(1)) begin
            state_d = ST_DONE;
            res_d   = calc_res;
          end
        end
        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MUL;
      sign_q  <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign out_result = res_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed self-checking bench for alu_muldiv (DATA_WIDTH=32).
// Latency is counted with the accepting edge as edge 1.
module tb_alu_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         flush = 1'b0;
  logic         out_ready = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_muldiv #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one edge; operands are scrambled afterwards.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op = o; src_a = a; src_b = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0; op = 3'd7; src_a = 32'hA5A5_5A5A; src_b = 32'h1234_5678;
  endtask

  task automatic wait_result(output int lat, output bit busy_ok);
    lat = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 200) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      step();
      lat++;
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL reset_out_result: got %h want 00000000", out_result); end
    $display("reset: in_ready=%b out_valid=%b out_result=%h", in_ready, out_valid, out_result);
  endtask

  task automatic test_mul();
    int lat; bit busy_ok;
    issue(3'd0, 32'd7, 32'hFFFF_FFFD);
    wait_result(lat, busy_ok);
    $display("MUL 7 x FFFFFFFD -> %h lat=%0d", out_result, lat);
    checks++; if (out_result !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result: got %h want ffffffeb", out_result); end
    checks++; if (lat != 33) begin errors++; $display("FAIL mul_latency: got %0d want 33", lat); end
    checks++; if (!busy_ok) begin errors++; $display("FAIL mul_busy: in_ready got 1 want 0 during CALC"); end
    pop();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL mul_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_mulh();
    logic [2:0]   ops[3] = '{3'd1, 3'd3, 3'd2};
    logic [W-1:0] as[3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [W-1:0] bs[3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [W-1:0] exp[3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    int lat; bit busy_ok;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_result(lat, busy_ok);
      $display("MULH* op=%0d %h x %h -> %h lat=%0d", ops[i], as[i], bs[i], out_result, lat);
      checks++; if (out_result !== exp[i]) begin errors++; $display("FAIL mulh_result[%0d]: got %h want %h", i, out_result, exp[i]); end
      pop();
    end
  endtask

  task automatic test_div();
    logic [2:0]   ops[4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [W-1:0] as[4]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [W-1:0] bs[4]  = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [W-1:0] exp[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    int lat; bit busy_ok;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_result(lat, busy_ok);
      $display("DIV* op=%0d %h / %h -> %h lat=%0d", ops[i], as[i], bs[i], out_result, lat);
      checks++; if (out_result !== exp[i]) begin errors++; $display("FAIL div_result[%0d]: got %h want %h", i, out_result, exp[i]); end
      checks++; if (lat != 33) begin errors++; $display("FAIL div_latency[%0d]: got %0d want 33", i, lat); end
      pop();
    end
  endtask

  task automatic test_special();
    logic [2:0]   ops[4] = '{3'd4, 3'd6, 3'd4, 3'd6};
    logic [W-1:0] as[4]  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [W-1:0] bs[4]  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [W-1:0] exp[4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int lat; bit busy_ok;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_result(lat, busy_ok);
      $display("special op=%0d %h / %h -> %h lat=%0d", ops[i], as[i], bs[i], out_result, lat);
      checks++; if (out_result !== exp[i]) begin errors++; $display("FAIL special_result[%0d]: got %h want %h", i, out_result, exp[i]); end
      checks++; if (lat != 1) begin errors++; $display("FAIL special_latency[%0d]: got %0d want 1", i, lat); end
      pop();
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit busy_ok;
    int unstable = 0;
    issue(3'd5, 32'd100, 32'd7);
    wait_result(lat, busy_ok);
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid !== 1'b1 || out_result !== 32'd14 || in_ready !== 1'b0) unstable++;
    end
    $display("backpressure: DIVU 100/7 held 10 cycles -> %h unstable=%0d", out_result, unstable);
    checks++; if (unstable != 0) begin errors++; $display("FAIL hold_stable: got %0d unstable cycles want 0", unstable); end
    pop();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL hold_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    issue(3'd0, 32'd6, 32'd7);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept: in_ready got %b want 0", in_ready); end
    wait_result(lat, busy_ok);
    $display("back-to-back: MUL 6 x 7 -> %h lat=%0d", out_result, lat);
    checks++; if (out_result !== 32'd42) begin errors++; $display("FAIL b2b_result: got %h want 0000002a", out_result); end
    checks++; if (lat != 33) begin errors++; $display("FAIL b2b_latency: got %0d want 33", lat); end
    pop();
  endtask

  task automatic test_flush();
    int lat; bit busy_ok;
    int rises = 0;
    // flush with a simultaneous request: request must be dropped
    op = 3'd0; src_a = 32'd3; src_b = 32'd3; in_valid = 1'b1; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_blocks_accept: in_ready got %b want 1", in_ready); end
    // flush mid-CALC
    issue(3'd0, 32'd7, 32'hFFFF_FFFD);
    repeat (4) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_idle: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid !== 1'b0) rises++;
    end
    $display("flush mid-CALC: out_valid high cycles=%0d", rises);
    checks++; if (rises != 0) begin errors++; $display("FAIL flush_no_result: got %0d valid cycles want 0", rises); end
    issue(3'd3, 32'd3, 32'd5);
    wait_result(lat, busy_ok);
    $display("after flush: MULHU 3 x 5 -> %h lat=%0d", out_result, lat);
    checks++; if (out_result !== 32'd0 || lat != 33) begin
      errors++; $display("FAIL flush_next_op: got %h lat=%0d want 00000000 lat=33", out_result, lat);
    end
    pop();
  endtask

  task automatic test_reset_mid();
    int lat; bit busy_ok;
    int rises = 0;
    issue(3'd5, 32'd100, 32'd7);
    wait_result(lat, busy_ok);
    pop();
    checks++; if (out_result !== 32'd14) begin errors++; $display("FAIL pre_reset_result: got %h want 0000000e", out_result); end
    issue(3'd0, 32'd7, 32'hFFFF_FFFD);
    repeat (4) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    $display("reset mid-CALC: in_ready=%b out_valid=%b out_result=%h", in_ready, out_valid, out_result);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 32'd0) begin
      errors++; $display("FAIL reset_mid: in_ready=%b out_valid=%b out_result=%h want 1/0/00000000", in_ready, out_valid, out_result);
    end
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid !== 1'b0) rises++;
    end
    checks++; if (rises != 0) begin errors++; $display("FAIL reset_no_result: got %0d valid cycles want 0", rises); end
    issue(3'd7, 32'd100, 32'd7);
    wait_result(lat, busy_ok);
    $display("after reset: REMU 100 / 7 -> %h lat=%0d", out_result, lat);
    checks++; if (out_result !== 32'd2) begin errors++; $display("FAIL reset_next_op: got %h want 00000002", out_result); end
    pop();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
